// File: rtl/filter_inverse_fixed_if.sv
// Sample handshake between a source (master) and the inverse filter (slave):
// request side carries y[n], response side carries x[n] plus its clip flag.
interface filter_inverse_fixed_if #(
    parameter int REG_MAX = 32
);
    logic signed [REG_MAX-1:0] filter_input;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [REG_MAX-1:0] filter_output;
    logic                      out_valid;
    logic                      out_sat;

    modport master (
        output filter_input, in_valid,
        input  in_ready, filter_output, out_valid, out_sat
    );

    modport slave (
        input  filter_input, in_valid,
        output in_ready, filter_output, out_valid, out_sat
    );
endinterface

// File: rtl/filter_inverse_fixed.sv
// First-order fixed-point inverse filter: x[n] = sat((B0*y[n] + B1*y[n-1] + A1*x[n-1]) >>> SHIFT),
// one shared signed multiplier stepped over three MAC states per accepted sample.
module filter_inverse_fixed #(
    parameter int REG_MAX    = 32,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_B0    = 16,
    parameter int COEF_B1    = -15,
    parameter int COEF_A1    = 0,
    parameter int SHIFT      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    filter_inverse_fixed_if.slave  bus
);
    localparam int PW = REG_MAX + COEF_WIDTH;
    localparam int AW = PW + 2;

    localparam logic signed [COEF_WIDTH-1:0] C_B0 = COEF_WIDTH'(COEF_B0);
    localparam logic signed [COEF_WIDTH-1:0] C_B1 = COEF_WIDTH'(COEF_B1);
    localparam logic signed [COEF_WIDTH-1:0] C_A1 = COEF_WIDTH'(COEF_A1);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-REG_MAX+1){1'b0}}, {(REG_MAX-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-REG_MAX+1){1'b1}}, {(REG_MAX-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_M0, S_M1, S_M2} state_t;

    state_t                    r_state;
    logic signed [REG_MAX-1:0] r_y_cur;
    logic signed [REG_MAX-1:0] r_y1;
    logic signed [REG_MAX-1:0] r_x1;
    logic signed [REG_MAX-1:0] r_out;
    logic signed [AW-1:0]      r_acc;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_out_sat;

    logic signed [COEF_WIDTH-1:0] w_coef;
    logic signed [REG_MAX-1:0]    w_opnd;
    logic signed [PW-1:0]         w_prod;
    logic signed [AW-1:0]         w_prod_ext;
    logic signed [AW-1:0]         w_sum;
    logic signed [AW-1:0]         w_shift;
    logic signed [REG_MAX-1:0]    w_sat_val;
    logic                         w_clip;

    // The state alone picks the multiplier operands, so only one product exists per cycle.
    always_comb begin
        w_coef = C_B0;
        w_opnd = r_y_cur;
        case (r_state)
            S_M1: begin
                w_coef = C_B1;
                w_opnd = r_y1;
            end
            S_M2: begin
                w_coef = C_A1;
                w_opnd = r_x1;
            end
            default: ;
        endcase
    end

    assign w_prod     = PW'(w_coef) * PW'(w_opnd);
    assign w_prod_ext = AW'(w_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shift    = w_sum >>> SHIFT;

    always_comb begin
        w_clip    = 1'b0;
        w_sat_val = w_shift[REG_MAX-1:0];
        if (w_shift > SAT_MAX) begin
            w_clip    = 1'b1;
            w_sat_val = SAT_MAX[REG_MAX-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_clip    = 1'b1;
            w_sat_val = SAT_MIN[REG_MAX-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_y_cur     <= '0;
            r_y1        <= '0;
            r_x1        <= '0;
            r_out       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_y_cur    <= bus.filter_input;
                        r_in_ready <= 1'b0;
                        r_state    <= S_M0;
                    end
                end
                S_M0: begin
                    r_acc   <= w_prod_ext;
                    r_state <= S_M1;
                end
                S_M1: begin
                    r_acc   <= w_sum;
                    r_state <= S_M2;
                end
                S_M2: begin
                    // Feedback history keeps the clipped value, matching what was emitted.
                    r_out       <= w_sat_val;
                    r_out_sat   <= w_clip;
                    r_out_valid <= 1'b1;
                    r_y1        <= r_y_cur;
                    r_x1        <= w_sat_val;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.filter_output = r_out;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_sat       = r_out_sat;
endmodule
